// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with in-order commit and taken-branch flush; optional macro ROB_BYPASS_EN
module rob_commit #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              alloc_valid,
   input  logic [3:0]        alloc_func,
   input  logic [3:0]        alloc_rd,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              cdb_taken,
   input  logic [TAG_W-1:0]  qry_tag,
   output logic              qry_ready,
   output logic [DATA_W-1:0] qry_data,
   output logic              commit_valid,
   output logic              commit_we,
   output logic              commit_store,
   output logic [3:0]        commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              flush,
   output logic [3:0]        flush_imm
);

   localparam logic [TAG_W:0]   L_DEPTH = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] L_ONE   = TAG_W'(1);
   localparam logic [TAG_W:0]   L_CONE  = (TAG_W+1)'(1);

   logic [DEPTH-1:0]  r_busy;
   logic [DEPTH-1:0]  r_done;
   logic [DEPTH-1:0]  r_taken;
   logic [3:0]        r_func  [DEPTH];
   logic [3:0]        r_rd    [DEPTH];
   logic [DATA_W-1:0] r_value [DEPTH];
   logic [TAG_W-1:0]  r_head_p;
   logic [TAG_W-1:0]  r_tail_p;
   logic [TAG_W:0]    r_count;

   logic              w_alloc_fire;
   logic              w_wb_fire;
   logic              w_commit_fire;
   logic              w_head_branch;
   logic              w_flush_fire;
   logic [3:0]        w_head_func;

   // flush is the registered pulse, so allocation is also held off the cycle after a flush
   assign alloc_ready   = (r_count < L_DEPTH) & ~flush;
   assign alloc_tag     = r_tail_p;
   assign w_alloc_fire  = alloc_valid & alloc_ready;
   assign w_wb_fire     = cdb_valid & r_busy[cdb_tag];
   assign w_head_func   = r_func[r_head_p];
   assign w_commit_fire = r_busy[r_head_p] & r_done[r_head_p];
   assign w_head_branch = (w_head_func == 4'b0110) | (w_head_func == 4'b0111);
   assign w_flush_fire  = w_commit_fire & w_head_branch & r_taken[r_head_p];

   // entry status bits and pointers; flush is applied last so it overrides alloc and writeback
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= '0;
         r_done   <= '0;
         r_taken  <= '0;
         r_head_p <= '0;
         r_tail_p <= '0;
         r_count  <= '0;
      end else begin
         if (w_alloc_fire) begin
            r_busy[r_tail_p]  <= 1'b1;
            r_done[r_tail_p]  <= 1'b0;
            r_taken[r_tail_p] <= 1'b0;
            r_tail_p          <= r_tail_p + L_ONE;
         end
         if (w_wb_fire) begin
            r_done[cdb_tag]  <= 1'b1;
            r_taken[cdb_tag] <= cdb_taken;
         end
         if (w_commit_fire) begin
            r_busy[r_head_p] <= 1'b0;
            r_head_p         <= r_head_p + L_ONE;
         end
         case ({w_alloc_fire, w_commit_fire})
            2'b10:   r_count <= r_count + L_CONE;
            2'b01:   r_count <= r_count - L_CONE;
            default: r_count <= r_count;
         endcase
         if (w_flush_fire) begin
            r_busy   <= '0;
            r_done   <= '0;
            r_taken  <= '0;
            r_head_p <= '0;
            r_tail_p <= '0;
            r_count  <= '0;
         end
      end
   end

   // payload fields need no reset; they are only read while the busy bit qualifies them
   always_ff @(posedge clk1) begin
      if (w_alloc_fire) begin
         r_func[r_tail_p] <= alloc_func;
         r_rd[r_tail_p]   <= alloc_rd;
      end
      if (w_wb_fire) begin
         r_value[cdb_tag] <= cdb_data;
      end
   end

   // registered commit and flush outputs decoded from the retiring head entry
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid <= 1'b0;
         commit_we    <= 1'b0;
         commit_store <= 1'b0;
         commit_rd    <= '0;
         commit_data  <= '0;
         commit_tag   <= '0;
         flush        <= 1'b0;
         flush_imm    <= '0;
      end else begin
         commit_valid <= w_commit_fire;
         commit_we    <= w_commit_fire & (w_head_func <= 4'b0100);
         commit_store <= w_commit_fire & (w_head_func == 4'b0101);
         flush        <= w_flush_fire;
         if (w_commit_fire) begin
            commit_rd   <= r_rd[r_head_p];
            commit_data <= r_value[r_head_p];
            commit_tag  <= r_head_p;
         end
         if (w_flush_fire) begin
            flush_imm <= r_rd[r_head_p];
         end
      end
   end

   // operand lookup for issue, optionally forwarding the CDB in the same cycle
   always_comb begin
      qry_ready = r_busy[qry_tag] & r_done[qry_tag];
      qry_data  = r_value[qry_tag];
`ifdef ROB_BYPASS_EN
      if (cdb_valid && (cdb_tag == qry_tag) && r_busy[qry_tag]) begin
         qry_ready = 1'b1;
         qry_data  = cdb_data;
      end
`endif
   end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed vector bench for rob_commit
module tb_rob_commit;

`ifdef ROB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        alloc_valid;
   logic [3:0]  alloc_func;
   logic [3:0]  alloc_rd;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        cdb_taken;
   logic [2:0]  qry_tag;
   logic        qry_ready;
   logic [15:0] qry_data;
   logic        commit_valid;
   logic        commit_we;
   logic        commit_store;
   logic [3:0]  commit_rd;
   logic [15:0] commit_data;
   logic [2:0]  commit_tag;
   logic        flush;
   logic [3:0]  flush_imm;

   int total = 0;
   int bad   = 0;

   rob_commit #(.DEPTH(8), .TAG_W(3), .DATA_W(16)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
      .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_data(qry_data),
      .commit_valid(commit_valid), .commit_we(commit_we), .commit_store(commit_store),
      .commit_rd(commit_rd), .commit_data(commit_data), .commit_tag(commit_tag),
      .flush(flush), .flush_imm(flush_imm)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      logic        av;
      logic [3:0]  af;
      logic [3:0]  ard;
      logic        cv;
      logic [2:0]  ct;
      logic [15:0] cd;
      logic        ctk;
      logic [2:0]  qt;
      logic        e_ar;
      logic [2:0]  e_at;
      logic        e_cv;
      logic        e_we;
      logic        e_st;
      logic [3:0]  e_rd;
      logic [15:0] e_data;
      logic [2:0]  e_tag;
      logic        e_fl;
      logic [3:0]  e_fimm;
      logic        e_qr;
      logic [15:0] e_qd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic av, input logic [3:0] af, input logic [3:0] ard,
      input logic cv, input logic [2:0] ct, input logic [15:0] cd, input logic ctk,
      input logic [2:0] qt,
      input logic e_ar, input logic [2:0] e_at,
      input logic e_cv, input logic e_we, input logic e_st, input logic [3:0] e_rd,
      input logic [15:0] e_data, input logic [2:0] e_tag,
      input logic e_fl, input logic [3:0] e_fimm,
      input logic e_qr, input logic [15:0] e_qd);
      vec_t v;
      v.av = av; v.af = af; v.ard = ard;
      v.cv = cv; v.ct = ct; v.cd = cd; v.ctk = ctk; v.qt = qt;
      v.e_ar = e_ar; v.e_at = e_at;
      v.e_cv = e_cv; v.e_we = e_we; v.e_st = e_st; v.e_rd = e_rd;
      v.e_data = e_data; v.e_tag = e_tag;
      v.e_fl = e_fl; v.e_fimm = e_fimm; v.e_qr = e_qr; v.e_qd = e_qd;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alloc_valid = v.av; alloc_func = v.af; alloc_rd = v.ard;
      cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd; cdb_taken = v.ctk;
      qry_tag = v.qt;
   endtask

   task automatic idle_in();
      alloc_valid = 0; alloc_func = 0; alloc_rd = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0; cdb_taken = 0; qry_tag = 0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      idle_in();
      //         av af    ard    cv ct cd      tk qt  ar at  cv we st rd     data    tag fl im   qr   qd
      // alloc, writeback, commit of a single add
      vecs.push_back(mk(1, 4'h0, 4'h3,  0, 0, 16'h0,  0, 0,  1, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 0, 16'h12, 0, 0,  1, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, BYP, 16'h12));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 0,  1, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 1,   16'h12));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 0,  1, 1,  1, 1, 0, 4'h3, 16'h12, 0,  0, 4'h0, 0,   16'h0));
      // out-of-order completion, in-order retirement
      vecs.push_back(mk(1, 4'h1, 4'h1,  0, 0, 16'h0,  0, 7,  1, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h2, 4'h2,  0, 0, 16'h0,  0, 7,  1, 2,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'h4,  0, 0, 16'h0,  0, 7,  1, 3,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 3, 16'h5,  0, 7,  1, 4,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 2, 16'h6,  0, 7,  1, 4,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 1, 16'h7,  0, 7,  1, 4,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 4,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 4,  1, 1, 0, 4'h1, 16'h7,  1,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 4,  1, 1, 0, 4'h2, 16'h6,  2,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 4,  1, 1, 0, 4'h4, 16'h5,  3,  0, 4'h0, 0,   16'h0));
      // store, then not-taken bneq
      vecs.push_back(mk(1, 4'h5, 4'hA,  0, 0, 16'h0,  0, 7,  1, 4,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h7, 4'h2,  0, 0, 16'h0,  0, 7,  1, 5,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 4, 16'hAB, 0, 7,  1, 6,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 5, 16'h0,  0, 7,  1, 6,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 6,  1, 0, 1, 4'hA, 16'hAB, 4,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 7,  1, 6,  1, 0, 0, 4'h2, 16'h0,  5,  0, 4'h0, 0,   16'h0));
      // operand query with and without same-cycle forwarding; writeback to an idle entry
      vecs.push_back(mk(1, 4'h0, 4'h5,  0, 0, 16'h0,  0, 6,  1, 6,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 6, 16'h44, 0, 6,  1, 7,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, BYP, 16'h44));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 6,  1, 7,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 1,   16'h44));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 2, 16'h99, 0, 2,  1, 7,  1, 1, 0, 4'h5, 16'h44, 6,  0, 4'h0, 0,   16'h0));
      // taken beq behind nothing, add behind it, alloc in the flush cycle is dropped
      vecs.push_back(mk(1, 4'h6, 4'h9,  0, 0, 16'h0,  0, 2,  1, 7,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'h1,  0, 0, 16'h0,  0, 2,  1, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  1, 7, 16'h0,  1, 2,  1, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'h3,  1, 0, 16'h55, 0, 2,  1, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'h6,  0, 0, 16'h0,  0, 0,  0, 0,  1, 0, 0, 4'h9, 16'h0,  7,  1, 4'h9, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'h0,  0, 0, 16'h0,  0, 0,  1, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      // fill to full, ignored ninth alloc, full even during commit, wrap to tag 0
      for (int k = 1; k < 8; k++)
         vecs.push_back(mk(1, 4'h0, 4'(k), 0, 0, 16'h0, 0, 7,  1, 3'(k), 0, 0, 0, 4'h0, 16'h0, 0, 0, 4'h0, 0, 16'h0));
      vecs.push_back(mk(1, 4'h0, 4'hF,  0, 0, 16'h0,  0, 7,  0, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'hF,  1, 0, 16'h77, 0, 7,  0, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'hF,  0, 0, 16'h0,  0, 7,  0, 0,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(1, 4'h0, 4'hF,  0, 0, 16'h0,  0, 7,  1, 0,  1, 1, 0, 4'h0, 16'h77, 0,  0, 4'h0, 0,   16'h0));
      vecs.push_back(mk(0, 4'h0, 4'h0,  0, 0, 16'h0,  0, 0,  0, 1,  0, 0, 0, 4'h0, 16'h0,  0,  0, 4'h0, 0,   16'h0));

      // reset state
      @(negedge clk1);
      #2;
      chk("rst_alloc_ready", -1, 32'(alloc_ready), 32'd1);
      chk("rst_alloc_tag", -1, 32'(alloc_tag), 32'd0);
      chk("rst_commit_valid", -1, 32'(commit_valid), 32'd0);
      chk("rst_flush", -1, 32'(flush), 32'd0);
      @(negedge clk1);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk1);
         drive(vecs[i]);
         #2;
         chk("alloc_ready", i, 32'(alloc_ready), 32'(vecs[i].e_ar));
         chk("alloc_tag", i, 32'(alloc_tag), 32'(vecs[i].e_at));
         chk("commit_valid", i, 32'(commit_valid), 32'(vecs[i].e_cv));
         chk("flush", i, 32'(flush), 32'(vecs[i].e_fl));
         chk("qry_ready", i, 32'(qry_ready), 32'(vecs[i].e_qr));
         if (vecs[i].e_cv) begin
            chk("commit_we", i, 32'(commit_we), 32'(vecs[i].e_we));
            chk("commit_store", i, 32'(commit_store), 32'(vecs[i].e_st));
            chk("commit_rd", i, 32'(commit_rd), 32'(vecs[i].e_rd));
            chk("commit_data", i, 32'(commit_data), 32'(vecs[i].e_data));
            chk("commit_tag", i, 32'(commit_tag), 32'(vecs[i].e_tag));
         end
         if (vecs[i].e_fl)
            chk("flush_imm", i, 32'(flush_imm), 32'(vecs[i].e_fimm));
         if (vecs[i].e_qr)
            chk("qry_data", i, 32'(qry_data), 32'(vecs[i].e_qd));
      end

      // mid-run asynchronous reset with a full buffer in flight
      @(negedge clk1);
      idle_in();
      qry_tag = 3'd1;
      rst_n = 1'b0;
      #2;
      chk("midrst_alloc_ready", 100, 32'(alloc_ready), 32'd1);
      chk("midrst_alloc_tag", 100, 32'(alloc_tag), 32'd0);
      chk("midrst_commit_valid", 100, 32'(commit_valid), 32'd0);
      chk("midrst_qry_ready", 100, 32'(qry_ready), 32'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      alloc_valid = 1'b1; alloc_func = 4'h0; alloc_rd = 4'h3;
      #2;
      chk("post_rst_alloc_tag", 101, 32'(alloc_tag), 32'd0);
      @(negedge clk1);
      idle_in();
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0012;
      @(negedge clk1);
      idle_in();
      n = 0;
      while (commit_valid !== 1'b1 && n < 5) begin
         @(negedge clk1);
         n++;
      end
      #2;
      chk("post_rst_latency", 102, 32'(n), 32'd1);
      chk("post_rst_commit_we", 102, 32'(commit_we), 32'd1);
      chk("post_rst_commit_rd", 102, 32'(commit_rd), 32'd3);
      chk("post_rst_commit_data", 102, 32'(commit_data), 32'h12);
      chk("post_rst_commit_tag", 102, 32'(commit_tag), 32'd0);
      @(negedge clk1);
      #2;
      chk("post_rst_single_pulse", 103, 32'(commit_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order commit stage; sits directly downstream of the issue stage.
- Issue allocates one entry per decoded instruction. Execution units write results back over the CDB.
- This block retires the head entry in program order to the register bank or store queue, and flushes on a taken branch.
- Issue also uses a tag-lookup port to fetch forwarded operands.

Parameters:
- DEPTH, 8, number of ROB entries; must be a power of 2.
- TAG_W, 3, entry index width; equals log2(DEPTH).
- DATA_W, 16, result data width.

Ports:
- clk1  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue requests a new entry this cycle.
- alloc_func  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110 beq, 0111 bneq.
- alloc_rd  in  4  destination register; branch imm[3:0]; store address nibble.
- alloc_ready  out  1  combinational; high when count < DEPTH and flush is low.
- alloc_tag  out  TAG_W  combinational; tail index assigned to the request.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  entry being completed.
- cdb_data  in  DATA_W  result value; store data for store entries.
- cdb_taken  in  1  branch outcome; ignored for non-branches.
- qry_tag  in  TAG_W  operand lookup tag.
- qry_ready  out  1  combinational; entry busy and done.
- qry_data  out  DATA_W  combinational; entry value.
- commit_valid  out  1  registered; one-cycle pulse per retired entry.
- commit_we  out  1  registered; regbank write enable. High for func 0000–0100.
- commit_store  out  1  registered; high for func 0101.
- commit_rd  out  4  registered.
- commit_data  out  DATA_W  registered.
- commit_tag  out  TAG_W  registered.
- flush  out  1  registered; one-cycle pulse on a taken-branch commit.
- flush_imm  out  4  registered; branch imm of the flushing branch.

Behaviour:
- Entry fields: busy, done, taken, func[3:0], rd[3:0], value[DATA_W-1:0].
- Pointers: head_p and tail_p are TAG_W wide and wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset: clears all busy/done bits, head_p = tail_p = 0, count = 0. All registered outputs go to 0. Reset is honoured mid-operation; all in-flight entries are lost.
- Allocate: on alloc_valid & alloc_ready, entry[tail_p] gets busy=1, done=0, taken=0, func and rd; tail_p increments.
- Allocate when alloc_ready is low: the request is ignored and nothing changes. Issue must hold the request.
- Writeback: on cdb_valid with entry[cdb_tag].busy, set done=1, value=cdb_data, taken=cdb_taken.
- Writeback to a non-busy entry is ignored. Writeback to an already-done entry overwrites it.
- Commit condition: at each edge, if entry[head_p].busy & done, retire it.
  - Clear busy, increment head_p.
  - Register commit_valid=1 plus the decoded commit_we/commit_store, rd, data and tag.
  - At most one commit per cycle.
- Commit latency: a CDB write at edge N makes the entry done. If that entry is the head, commit_valid is high after edge N+1, i.e. one cycle minimum from CDB to commit.
- Branch resolution on commit of func 0110/0111:
  - taken=1: flush=1 and flush_imm=rd for one cycle. All entries are invalidated in the same edge, head_p = tail_p = 0, count = 0.
  - taken=0: commit_valid pulses with commit_we=0 and no flush.
- Simultaneous events:
  - Alloc + commit in the same cycle: count is unchanged.
  - Alloc + flush-commit in the same cycle: the alloc is dropped.
  - A CDB write to the head entry in the same cycle it becomes done: commit happens next cycle, not the same cycle.
- Full: count == DEPTH deasserts alloc_ready, even if a commit occurs that cycle. alloc_ready reasserts the cycle after the commit.
- Empty: head_p == tail_p with count == 0; no commit is possible.

Optional Feature:
- ROB_BYPASS_EN.
- Defined: if cdb_valid & cdb_tag == qry_tag and the entry is busy, then qry_ready=1 and qry_data=cdb_data in the same cycle (CDB-to-issue forwarding).
- Undefined: qry reflects stored state only; the result is visible one cycle after the CDB write.

Test Plan:
- Reset with rst_n=0 mid-run, then allocate add rd=3 -> alloc_tag=0. CDB tag0 data=0x0012 -> next edge commit_valid=1, commit_we=1, rd=3, data=0x0012.
- Out-of-order completion: allocate tags 0, 1, 2; CDB writes tag2=0x5, then tag1=0x6, then tag0=0x7 -> commits on consecutive cycles in order tag0, tag1, tag2.
- Full: 8 allocs with no CDB -> alloc_ready=0 and a 9th alloc is ignored. Complete tag0 -> one commit, then alloc_ready=1 and the next alloc_tag=0 (wrap-around).
- Taken branch: allocate beq imm=0x9 (tag0) then add (tag1); CDB tag0 taken=1 -> flush=1, flush_imm=0x9, no commit of tag1, count=0, next alloc_tag=0.
- Store and not-taken branch: CDB store tag data=0x00AB -> commit_store=1, commit_we=0. bneq with taken=0 -> commit_valid=1, flush=0.
- Query: CDB tag3=0x0044 -> same cycle qry_ready=1 with ROB_BYPASS_EN defined, 0 without it; next cycle qry_ready=1, qry_data=0x0044 in both builds.
